// File: rtl/alu_issue_stage.sv
// Decode/issue stage: decodes RV32I into ALU opcode and operands, registers the
// ALU-facing bundle in the ID/EX register, and handles load-use bubbles, stall and flush.
module alu_issue_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [XLEN-1:0]       pc,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic                  flush_i,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [XLEN-1:0]       ex_operand1,
  output logic [XLEN-1:0]       ex_operand2,
  output logic [3:0]            ex_alu_control,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_branch,
  output logic                  ex_illegal,
  output logic [2:0]            ex_funct3
);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluAnd = 4'b0010;
  localparam logic [3:0] AluOr  = 4'b0011;
  localparam logic [3:0] AluXor = 4'b0100;
  localparam logic [3:0] AluSll = 4'b0101;
  localparam logic [3:0] AluSrl = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1000;
  localparam logic [3:0] AluSra = 4'b1001;

  typedef struct packed {
    logic [XLEN-1:0]       op1;
    logic [XLEN-1:0]       op2;
    logic [3:0]            alu;
    logic [XLEN-1:0]       rs2_data;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic                  illegal;
    logic [2:0]            funct3;
  } bundle_t;

  // Returns {legal, alu_opcode} for the funct7=0000000 (and OP-IMM) funct3 map.
  function automatic logic [4:0] base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return {1'b1, AluAdd};
      3'b001:  return {1'b1, AluSll};
      3'b010:  return {1'b1, AluSlt};
      3'b100:  return {1'b1, AluXor};
      3'b101:  return {1'b1, AluSrl};
      3'b110:  return {1'b1, AluOr};
      3'b111:  return {1'b1, AluAnd};
      default: return {1'b0, AluAdd};
    endcase
  endfunction

  function automatic logic [4:0] alt_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return {1'b1, AluSub};
      3'b101:  return {1'b1, AluSra};
      3'b110:  return {1'b1, AluNor};
      default: return {1'b0, AluAdd};
    endcase
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_u;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = XLEN'($signed(instr[31:20]));
  assign imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_u  = XLEN'($signed({instr[31:12], 12'h000}));

  logic            legal;
  logic [3:0]      alu;
  logic            rw, mr, mw, br;
  logic            uses_rs1, uses_rs2;
  logic [XLEN-1:0] op1, op2;

  always_comb begin
    legal    = 1'b1;
    alu      = AluAdd;
    rw       = 1'b0;
    mr       = 1'b0;
    mw       = 1'b0;
    br       = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    op1      = rs1_data;
    op2      = rs2_data;
    case (opcode)
      OpcOp: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        rw       = 1'b1;
        if (funct7 == F7Base) begin
          {legal, alu} = base_alu(funct3);
        end else if (funct7 == F7Alt) begin
          {legal, alu} = alt_alu(funct3);
        end else begin
          legal = 1'b0;
        end
      end
      OpcOpImm: begin
        uses_rs1     = 1'b1;
        rw           = 1'b1;
        op2          = imm_i;
        {legal, alu} = base_alu(funct3);
        // Shift immediates carry funct7 in the upper imm bits; instr[30] picks SRA.
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          if (funct7 != F7Base && funct7 != F7Alt) legal = 1'b0;
          if (funct3 == 3'b101 && instr[30]) alu = AluSra;
        end
      end
      OpcLoad: begin
        uses_rs1 = 1'b1;
        rw       = 1'b1;
        mr       = 1'b1;
        op2      = imm_i;
        legal    = (funct3 != 3'b011);
      end
      OpcStore: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        mw       = 1'b1;
        op2      = imm_s;
        legal    = (funct3 != 3'b011);
      end
      OpcBranch: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        br       = 1'b1;
        case (funct3)
          3'b000, 3'b001: alu = AluSub;
          3'b100, 3'b101: alu = AluSlt;
          default:        legal = 1'b0;
        endcase
      end
      OpcLui: begin
        rw  = 1'b1;
        op1 = '0;
        op2 = imm_u;
      end
      OpcAuipc: begin
        rw  = 1'b1;
        op1 = pc;
        op2 = imm_u;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      alu = AluAdd;
      rw  = 1'b0;
      mr  = 1'b0;
      mw  = 1'b0;
      br  = 1'b0;
    end
    if (instr[11:7] == 5'd0) rw = 1'b0;
  end

  bundle_t dec;

  always_comb begin
    dec           = '0;
    dec.op1       = op1;
    dec.op2       = op2;
    dec.alu       = alu;
    dec.rs2_data  = rs2_data;
    dec.rd        = REG_ADDR_W'(instr[11:7]);
    dec.rs1       = REG_ADDR_W'(instr[19:15]);
    dec.rs2       = REG_ADDR_W'(instr[24:20]);
    dec.reg_write = rw;
    dec.mem_read  = mr;
    dec.mem_write = mw;
    dec.branch    = br;
    dec.illegal   = !legal;
    dec.funct3    = funct3;
  end

  logic    out_valid_q, out_valid_d;
  bundle_t bundle_q, bundle_d;
  logic    hazard, accept;

  // Holding the dependent instr while the load drains naturally yields one bubble.
  assign hazard = out_valid_q && bundle_q.mem_read && (bundle_q.rd != '0) &&
                  (((bundle_q.rd == dec.rs1) && uses_rs1) ||
                   ((bundle_q.rd == dec.rs2) && uses_rs2));
  assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush_i;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      bundle_d    = dec;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign ex_operand1    = bundle_q.op1;
  assign ex_operand2    = bundle_q.op2;
  assign ex_alu_control = bundle_q.alu;
  assign ex_rs2_data    = bundle_q.rs2_data;
  assign ex_rd          = bundle_q.rd;
  assign ex_rs1         = bundle_q.rs1;
  assign ex_rs2         = bundle_q.rs2;
  assign ex_reg_write   = bundle_q.reg_write;
  assign ex_mem_read    = bundle_q.mem_read;
  assign ex_mem_write   = bundle_q.mem_write;
  assign ex_branch      = bundle_q.branch;
  assign ex_illegal     = bundle_q.illegal;
  assign ex_funct3      = bundle_q.funct3;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed decode table, hand-written
// hazard/stall/flush/reset sequences, and randomized traffic against a cycle model.
module tb_alu_issue_stage;

  logic        clk, rst_n, in_valid, in_ready, flush_i, out_ready, out_valid;
  logic [31:0] instr, pc, rs1_data, rs2_data;
  logic [31:0] ex_operand1, ex_operand2, ex_rs2_data;
  logic [3:0]  ex_alu_control;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;
  logic [2:0]  ex_funct3;

  int n_vec = 0;
  int n_err = 0;

  alu_issue_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush_i(flush_i),
    .out_ready(out_ready), .out_valid(out_valid), .ex_operand1(ex_operand1),
    .ex_operand2(ex_operand2), .ex_alu_control(ex_alu_control), .ex_rs2_data(ex_rs2_data),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_illegal(ex_illegal), .ex_funct3(ex_funct3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  alu;
    logic [31:0] rs2d;
    logic [4:0]  rd, rs1, rs2;
    logic        rw, mr, mw, br, ill;
    logic [2:0]  f3;
  } bun_t;

  typedef struct {
    string       name;
    logic [31:0] ins, pcv, r1, r2, op1, op2;
    logic [3:0]  alu;
    logic [4:0]  fl;  // {reg_write, mem_read, mem_write, branch, illegal}
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bun_t get_act();
    bun_t b;
    b = {ex_operand1, ex_operand2, ex_alu_control, ex_rs2_data, ex_rd, ex_rs1, ex_rs2,
         ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal, ex_funct3};
    return b;
  endfunction

  // Operands of an illegal instruction are don't-care.
  function automatic bun_t mask(input bun_t b, input logic ill);
    bun_t m;
    m = b;
    if (ill) begin
      m.op1 = '0;
      m.op2 = '0;
    end
    return m;
  endfunction

  // Reference decoder written from the instruction-set rules.
  function automatic bun_t ref_decode(input logic [31:0] ins, input logic [31:0] pcv,
                                      input logic [31:0] r1, input logic [31:0] r2);
    bun_t b;
    int   base_map[8];
    int   alt_map[8];
    int   code;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [31:0] ii, si, ui;
    base_map = '{0, 5, 7, -1, 4, 6, 3, 2};
    alt_map  = '{1, -1, -1, -1, -1, 9, 8, -1};
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    ii  = {{20{ins[31]}}, ins[31:20]};
    si  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ui  = {ins[31:12], 12'h000};
    b      = '0;
    b.rd   = ins[11:7];
    b.rs1  = ins[19:15];
    b.rs2  = ins[24:20];
    b.f3   = f3;
    b.rs2d = r2;
    b.op1  = r1;
    b.op2  = r2;
    code   = -1;
    case (opc)
      7'h33: begin
        b.rw = 1'b1;
        if (f7 == 7'h00) code = base_map[f3];
        else if (f7 == 7'h20) code = alt_map[f3];
      end
      7'h13: begin
        b.rw  = 1'b1;
        b.op2 = ii;
        code  = base_map[f3];
        if ((f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00 && f7 != 7'h20) code = -1;
        else if (f3 == 3'd5 && ins[30]) code = 9;
      end
      7'h03: begin
        b.rw = 1'b1; b.mr = 1'b1; b.op2 = ii;
        code = (f3 == 3'd3) ? -1 : 0;
      end
      7'h23: begin
        b.mw = 1'b1; b.op2 = si;
        code = (f3 == 3'd3) ? -1 : 0;
      end
      7'h63: begin
        b.br = 1'b1;
        if (f3 == 3'd0 || f3 == 3'd1) code = 1;
        else if (f3 == 3'd4 || f3 == 3'd5) code = 7;
      end
      7'h37: begin b.rw = 1'b1; b.op1 = 32'd0; b.op2 = ui; code = 0; end
      7'h17: begin b.rw = 1'b1; b.op1 = pcv;   b.op2 = ui; code = 0; end
      default: code = -1;
    endcase
    if (code < 0) begin
      b.ill = 1'b1; b.alu = 4'd0;
      b.rw = 1'b0; b.mr = 1'b0; b.mw = 1'b0; b.br = 1'b0;
    end else begin
      b.alu = 4'(code);
    end
    if (b.rd == 5'd0) b.rw = 1'b0;
    return b;
  endfunction

  function automatic logic uses1(input logic [6:0] o);
    return o == 7'h33 || o == 7'h13 || o == 7'h03 || o == 7'h23 || o == 7'h63;
  endfunction

  function automatic logic uses2(input logic [6:0] o);
    return o == 7'h33 || o == 7'h23 || o == 7'h63;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0]  opcs[8];
    logic [31:0] w;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h7F};
    w = $urandom();
    case ($urandom_range(0, 3))
      0, 1:    w[31:25] = 7'h00;
      2:       w[31:25] = 7'h20;
      default: w[31:25] = w[31:25];
    endcase
    w[24:20] = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[11:7]  = 5'($urandom_range(0, 3));
    w[6:0]   = opcs[$urandom_range(0, 7)];
    return w;
  endfunction

  task automatic add(input string n, input logic [31:0] ins, input logic [31:0] pcv,
                     input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] op1,
                     input logic [31:0] op2, input logic [3:0] alu, input logic [4:0] fl);
    vec_t v;
    v.name = n; v.ins = ins; v.pcv = pcv; v.r1 = r1; v.r2 = r2;
    v.op1 = op1; v.op2 = op2; v.alu = alu; v.fl = fl;
    tbl.push_back(v);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; flush_i = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    instr = ins; rs1_data = r1; rs2_data = r2; in_valid = 1'b1;
  endtask

  localparam logic [31:0] A = 32'h1111_1111;
  localparam logic [31:0] B = 32'h2222_2222;
  localparam logic [31:0] P = 32'h0000_1000;

  bun_t        expb, actb;
  logic        mvalid;
  bun_t        mb;
  logic        exp_rdy, hz;
  logic [31:0] exp_v, act_v;
  int          waited;

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; flush_i = 1'b0; out_ready = 1'b1;
    instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;

    // Reset with random inputs.
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; instr = $urandom(); rs1_data = $urandom(); rs2_data = $urandom();
      pc = $urandom(); out_ready = 1'($urandom()); flush_i = 1'($urandom());
      step();
      chk("reset_valid", 128'(out_valid), 128'(0));
      chk("reset_bundle", 128'(get_act()), 128'(0));
    end
    in_valid = 1'b0; flush_i = 1'b0; out_ready = 1'b1;
    #2 rst_n = 1'b1;
    #1 chk("reset_in_ready", 128'(in_ready), 128'(1));

    // Directed decode table.
    add("add",      32'h002081B3, P, 32'd5, 32'd7, 32'd5, 32'd7, 4'd0, 5'b10000);
    add("sub",      32'h402081B3, P, A, B, A, B, 4'd1, 5'b10000);
    add("and",      32'h0020F1B3, P, A, B, A, B, 4'd2, 5'b10000);
    add("or",       32'h0020E1B3, P, A, B, A, B, 4'd3, 5'b10000);
    add("xor",      32'h0020C1B3, P, A, B, A, B, 4'd4, 5'b10000);
    add("sll",      32'h002091B3, P, A, B, A, B, 4'd5, 5'b10000);
    add("srl",      32'h0020D1B3, P, A, B, A, B, 4'd6, 5'b10000);
    add("slt",      32'h0020A1B3, P, A, B, A, B, 4'd7, 5'b10000);
    add("nor",      32'h4020E1B3, P, A, B, A, B, 4'd8, 5'b10000);
    add("sra",      32'h4020D1B3, P, A, B, A, B, 4'd9, 5'b10000);
    add("addi_m1",  32'hFFF00093, P, 32'd0, B, 32'd0, 32'hFFFF_FFFF, 4'd0, 5'b10000);
    add("srai",     32'h40435293, P, A, B, A, 32'h0000_0404, 4'd9, 5'b10000);
    add("ori",      32'h7FF0E193, P, A, B, A, 32'h0000_07FF, 4'd3, 5'b10000);
    add("lui",      32'h12345237, P, A, B, 32'd0, 32'h1234_5000, 4'd0, 5'b10000);
    add("auipc",    32'hFFFFF397, P, A, B, P, 32'hFFFF_F000, 4'd0, 5'b10000);
    add("lw",       32'h00012083, P, A, B, A, 32'd0, 4'd0, 5'b11000);
    add("lw_neg",   32'hFFC12283, P, A, B, A, 32'hFFFF_FFFC, 4'd0, 5'b11000);
    add("sw",       32'h00312423, P, A, B, A, 32'd8, 4'd0, 5'b00100);
    add("sw_neg",   32'hFE312C23, P, A, B, A, 32'hFFFF_FFF8, 4'd0, 5'b00100);
    add("beq",      32'h00208063, P, A, B, A, B, 4'd1, 5'b00010);
    add("bne",      32'h00209063, P, A, B, A, B, 4'd1, 5'b00010);
    add("blt",      32'h0020C063, P, A, B, A, B, 4'd7, 5'b00010);
    add("bge",      32'h0020D063, P, A, B, A, B, 4'd7, 5'b00010);
    add("bltu",     32'h0020E063, P, A, B, 32'd0, 32'd0, 4'd0, 5'b00001);
    add("sltu",     32'h0020B1B3, P, A, B, 32'd0, 32'd0, 4'd0, 5'b00001);
    add("opc_7f",   32'h000001FF, P, A, B, 32'd0, 32'd0, 4'd0, 5'b00001);
    add("add_x0",   32'h00208033, P, A, B, A, B, 4'd0, 5'b00000);
    add("slli_bad", 32'h02009193, P, A, B, 32'd0, 32'd0, 4'd0, 5'b00001);
    add("op_bad",   32'h4020F1B3, P, A, B, 32'd0, 32'd0, 4'd0, 5'b00001);

    idle(1);
    foreach (tbl[i]) begin
      drive(tbl[i].ins, tbl[i].r1, tbl[i].r2);
      pc = tbl[i].pcv;
      #1;
      waited = 0;
      while (!in_ready && waited < 4) begin
        step();
        waited++;
      end
      if (!in_ready) begin
        n_vec++; n_err++;
        $display("FAIL %s_timeout: got in_ready 0 expected 1", tbl[i].name);
      end
      step();
      chk({tbl[i].name, "_valid"}, 128'(out_valid), 128'(1));
      actb = get_act();
      chk(tbl[i].name,
          128'({ex_illegal ? 32'd0 : actb.op1, ex_illegal ? 32'd0 : actb.op2, actb.alu,
                actb.rw, actb.mr, actb.mw, actb.br, actb.ill}),
          128'({tbl[i].op1, tbl[i].op2, tbl[i].alu, tbl[i].fl}));
    end

    // Load-use: LW x1,0(x2) then ADD x2,x1,x1.
    idle(2);
    drive(32'h00012083, 32'h100, 32'd0);
    #1 chk("lw_ready", 128'(in_ready), 128'(1));
    step();
    chk("lw_issue", 128'({out_valid, ex_mem_read, ex_rd}), 128'({1'b1, 1'b1, 5'd1}));
    drive(32'h00108133, 32'd9, 32'd9);
    #1 chk("hz_ready0", 128'(in_ready), 128'(0));
    step();
    chk("hz_bubble", 128'(out_valid), 128'(0));
    chk("hz_ready1", 128'(in_ready), 128'(1));
    step();
    chk("hz_issue", 128'({out_valid, ex_alu_control, ex_rs1, ex_rs2, ex_rd}),
        128'({1'b1, 4'd0, 5'd1, 5'd1, 5'd2}));

    // Stall for three cycles with a pending instruction.
    idle(2);
    drive(32'h002081B3, 32'd5, 32'd7);
    step();
    chk("add_x3", 128'({out_valid, ex_operand1, ex_operand2, ex_alu_control, ex_rd, ex_reg_write}),
        128'({1'b1, 32'd5, 32'd7, 4'd0, 5'd3, 1'b1}));
    expb = ref_decode(32'h002081B3, pc, 32'd5, 32'd7);
    out_ready = 1'b0;
    drive(32'h402081B3, 32'd1, 32'd2);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_ready", 128'(in_ready), 128'(0));
      step();
      chk("stall_valid", 128'(out_valid), 128'(1));
      chk("stall_hold", 128'(get_act()), 128'(expb));
    end
    out_ready = 1'b1;
    #1 chk("unstall_ready", 128'(in_ready), 128'(1));
    step();
    chk("unstall_issue", 128'({out_valid, ex_alu_control}), 128'({1'b1, 4'd1}));

    // Flush with a valid bundle held by a stall and a new instruction offered.
    idle(2);
    drive(32'hFFF00093, 32'd0, 32'd0);
    step();
    out_ready = 1'b0; flush_i = 1'b1;
    drive(32'h12345237, A, B);
    #1 chk("flush_ready", 128'(in_ready), 128'(0));
    step();
    chk("flush_clear", 128'(out_valid), 128'(0));
    flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("flush_dropped", 128'(out_valid), 128'(0));

    // Asynchronous reset mid-operation; nothing replays afterwards.
    idle(1);
    drive(32'h002081B3, A, B);
    step();
    #2 rst_n = 1'b0;
    #1 chk("areset_valid", 128'(out_valid), 128'(0));
    chk("areset_bundle", 128'(get_act()), 128'(0));
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    step();
    chk("areset_noreplay", 128'(out_valid), 128'(0));
    chk("areset_ready", 128'(in_ready), 128'(1));

    // Randomized traffic against a cycle-level model.
    idle(2);
    mvalid = 1'b0;
    mb = '0;
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush_i   = ($urandom_range(0, 15) == 0);
      instr     = gen_instr();
      pc        = $urandom();
      rs1_data  = $urandom();
      rs2_data  = $urandom();
      #1;
      hz = mvalid && mb.mr && (mb.rd != 5'd0) &&
           ((mb.rd == instr[19:15] && uses1(instr[6:0])) ||
            (mb.rd == instr[24:20] && uses2(instr[6:0])));
      exp_rdy = (!mvalid || out_ready) && !hz && !flush_i;
      chk("rnd_in_ready", 128'(in_ready), 128'(exp_rdy));
      if (flush_i) begin
        mvalid = 1'b0;
      end else if (in_valid && exp_rdy) begin
        mvalid = 1'b1;
        mb = ref_decode(instr, pc, rs1_data, rs2_data);
      end else if (out_ready) begin
        mvalid = 1'b0;
      end
      step();
      chk("rnd_out_valid", 128'(out_valid), 128'(mvalid));
      if (mvalid) begin
        chk("rnd_bundle", 128'(mask(get_act(), mb.ill)), 128'(mask(mb, mb.ill)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
